// File: rtl/blk_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : blk_sequencer
// Description : Splits an incoming video stream into a grid of HBLKS x VBLKS
//               blocks of HPX x VPX pixels. The pixel stream is forwarded
//               with one cycle of latency. Alongside it the module flags the
//               last pixel of each horizontal block (h_save_o), the end of
//               each block row (v_save_o) and the start of each frame
//               (frame_start_o), and reports the block coordinates of the
//               forwarded pixel. Lines that are too long or too short set a
//               sticky error flag.
// Ports       : clk_i         - clock, rising edge
//               rst_ni        - asynchronous active-low reset
//               vs_i          - vertical sync, active high
//               de_i          - data enable
//               wd_i[23:0]    - RGB pixel data
//               de_o, wd_o    - de_i / wd_i delayed one cycle
//               h_save_o      - last pixel of a block, aligned with de_o
//               v_save_o      - one cycle after the final h_save_o of a row
//               frame_start_o - pulse after a vs_i rising edge
//               blk_x_o       - block column of the de_o pixel
//               blk_y_o       - block row of the de_o pixel
//               err_o         - sticky line-length error
// Notes       : HBLKS, VBLKS, HPX and VPX must each be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module blk_sequencer #(
    parameter int HBLKS = 10,
    parameter int VBLKS = 10,
    parameter int HPX   = 30,
    parameter int VPX   = 30
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       vs_i,
    input  logic                       de_i,
    input  logic [23:0]                wd_i,
    output logic                       de_o,
    output logic [23:0]                wd_o,
    output logic                       h_save_o,
    output logic                       v_save_o,
    output logic                       frame_start_o,
    output logic [$clog2(HBLKS)-1:0]   blk_x_o,
    output logic [$clog2(VBLKS)-1:0]   blk_y_o,
    output logic                       err_o
);

    localparam int PXW = $clog2(HPX);
    localparam int XW  = $clog2(HBLKS);
    localparam int LW  = $clog2(VPX);
    localparam int YW  = $clog2(VBLKS);

    localparam logic [PXW-1:0] PX_LAST   = PXW'(HPX - 1);
    localparam logic [XW-1:0]  HBLK_LAST = XW'(HBLKS - 1);
    localparam logic [LW-1:0]  LINE_LAST = LW'(VPX - 1);
    localparam logic [YW-1:0]  VBLK_LAST = YW'(VBLKS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic            vs_prev;
    logic            vs_rise;
    logic [PXW-1:0]  px_cnt, px_cnt_nxt;
    logic [XW-1:0]   hblk_cnt, hblk_cnt_nxt;
    logic [LW-1:0]   line_cnt, line_cnt_nxt;
    logic [YW-1:0]   vblk_cnt, vblk_cnt_nxt;
    // All HBLKS blocks of the current line are complete; further pixels overflow.
    logic            line_full, line_full_nxt;
    // Last block of a row just finished; v_save_o follows one cycle later.
    logic            v_pend, v_pend_nxt;
    logic            h_save_nxt;
    logic            err_nxt;

    assign vs_rise = vs_i & ~vs_prev;

    always_comb begin
        state_nxt     = state;
        px_cnt_nxt    = px_cnt;
        hblk_cnt_nxt  = hblk_cnt;
        line_cnt_nxt  = line_cnt;
        vblk_cnt_nxt  = vblk_cnt;
        line_full_nxt = line_full;
        v_pend_nxt    = 1'b0;
        h_save_nxt    = 1'b0;
        err_nxt       = err_o;

        if (vs_rise) begin
            // A new frame restarts everything regardless of the current state;
            // the pixel presented in this cycle is not counted.
            state_nxt     = HBLANK;
            px_cnt_nxt    = '0;
            hblk_cnt_nxt  = '0;
            line_cnt_nxt  = '0;
            vblk_cnt_nxt  = '0;
            line_full_nxt = 1'b0;
        end else begin
            case (state)
                HBLANK, ACTIVE: begin
                    if (de_i) begin
                        // The first pixel of a line (arriving in HBLANK) counts too.
                        state_nxt = ACTIVE;
                        if (line_full) begin
                            err_nxt = 1'b1;
                        end else if (px_cnt == PX_LAST) begin
                            h_save_nxt = 1'b1;
                            px_cnt_nxt = '0;
                            if (hblk_cnt == HBLK_LAST) begin
                                hblk_cnt_nxt  = '0;
                                line_full_nxt = 1'b1;
                                v_pend_nxt    = (line_cnt == LINE_LAST);
                            end else begin
                                hblk_cnt_nxt = hblk_cnt + 1'b1;
                            end
                        end else begin
                            px_cnt_nxt = px_cnt + 1'b1;
                        end
                    end else if (state == ACTIVE) begin
                        // Line end: a short line is flagged but still counted.
                        state_nxt     = HBLANK;
                        if (!line_full) begin
                            err_nxt = 1'b1;
                        end
                        px_cnt_nxt    = '0;
                        hblk_cnt_nxt  = '0;
                        line_full_nxt = 1'b0;
                        if (line_cnt == LINE_LAST) begin
                            line_cnt_nxt = '0;
                            vblk_cnt_nxt = (vblk_cnt == VBLK_LAST) ? '0 : vblk_cnt + 1'b1;
                        end else begin
                            line_cnt_nxt = line_cnt + 1'b1;
                        end
                    end
                    // The pending v_save belongs to the row held in vblk_cnt
                    // (any line-end increment in this cycle is not yet visible).
                    if (v_pend && (vblk_cnt == VBLK_LAST)) begin
                        state_nxt = DONE;
                    end
                end
                default: begin
                    // IDLE waits for vs_i; DONE ignores de_i until the next frame.
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            vs_prev       <= 1'b0;
            px_cnt        <= '0;
            hblk_cnt      <= '0;
            line_cnt      <= '0;
            vblk_cnt      <= '0;
            line_full     <= 1'b0;
            v_pend        <= 1'b0;
            de_o          <= 1'b0;
            wd_o          <= '0;
            h_save_o      <= 1'b0;
            v_save_o      <= 1'b0;
            frame_start_o <= 1'b0;
            blk_x_o       <= '0;
            blk_y_o       <= '0;
            err_o         <= 1'b0;
        end else begin
            state         <= state_nxt;
            vs_prev       <= vs_i;
            px_cnt        <= px_cnt_nxt;
            hblk_cnt      <= hblk_cnt_nxt;
            line_cnt      <= line_cnt_nxt;
            vblk_cnt      <= vblk_cnt_nxt;
            line_full     <= line_full_nxt;
            v_pend        <= v_pend_nxt;
            de_o          <= de_i;
            wd_o          <= wd_i;
            h_save_o      <= h_save_nxt;
            v_save_o      <= v_pend & ~vs_rise;
            frame_start_o <= vs_rise;
            // Coordinates of the pixel being forwarded, taken before this
            // cycle's counter update.
            blk_x_o       <= vs_rise ? '0 : hblk_cnt;
            blk_y_o       <= vs_rise ? '0 : vblk_cnt;
            err_o         <= err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_blk_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_blk_sequencer
// Description : Self-checking bench for blk_sequencer with a 2x2 grid of
//               3x2-pixel blocks. A frame-level reference model tracks the
//               pixel index within the line and the line index within the
//               frame, and derives every expected output from those.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blk_sequencer;

    localparam int HBLKS = 2;
    localparam int VBLKS = 2;
    localparam int HPX   = 3;
    localparam int VPX   = 2;
    localparam int W     = HBLKS * HPX;

    logic                      clk = 1'b0;
    logic                      rst_ni = 1'b0;
    logic                      vs_i = 1'b0;
    logic                      de_i = 1'b0;
    logic [23:0]               wd_i = '0;
    logic                      de_o;
    logic [23:0]               wd_o;
    logic                      h_save_o;
    logic                      v_save_o;
    logic                      frame_start_o;
    logic [$clog2(HBLKS)-1:0]  blk_x_o;
    logic [$clog2(VBLKS)-1:0]  blk_y_o;
    logic                      err_o;

    blk_sequencer #(
        .HBLKS (HBLKS),
        .VBLKS (VBLKS),
        .HPX   (HPX),
        .VPX   (VPX)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .vs_i          (vs_i),
        .de_i          (de_i),
        .wd_i          (wd_i),
        .de_o          (de_o),
        .wd_o          (wd_o),
        .h_save_o      (h_save_o),
        .v_save_o      (v_save_o),
        .frame_start_o (frame_start_o),
        .blk_x_o       (blk_x_o),
        .blk_y_o       (blk_y_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state (frame level)
    bit m_vs_prev;
    bit m_started;   // a vs_i rising edge has been seen since reset
    bit m_done;      // all block rows of the frame delivered
    int m_k;         // pixels seen in the current line
    int m_L;         // lines completed since frame start
    bit m_inline;
    bit m_vpend;
    int m_vrow;
    bit m_err;

    task automatic model_reset();
        m_vs_prev = 0; m_started = 0; m_done = 0; m_k = 0; m_L = 0;
        m_inline = 0; m_vpend = 0; m_vrow = 0; m_err = 0;
    endtask

    task automatic check_zero(input string tag);
        check_value({tag, "_de"}, 32'(de_o), 0);
        check_value({tag, "_wd"}, 32'(wd_o), 0);
        check_value({tag, "_h"}, 32'(h_save_o), 0);
        check_value({tag, "_v"}, 32'(v_save_o), 0);
        check_value({tag, "_fs"}, 32'(frame_start_o), 0);
        check_value({tag, "_bx"}, 32'(blk_x_o), 0);
        check_value({tag, "_by"}, 32'(blk_y_o), 0);
        check_value({tag, "_err"}, 32'(err_o), 0);
    endtask

    // One clock: drive inputs, advance the model, check the registered outputs.
    task automatic step(input bit vs, input bit de);
        logic [23:0] wd;
        bit rise, eh, ev, chk_blk, nxt_pend;
        int ex, ey;
        wd = 24'($urandom);
        vs_i = vs; de_i = de; wd_i = wd;

        rise = vs && !m_vs_prev;
        m_vs_prev = vs;
        eh = 0; ev = m_vpend && !rise; chk_blk = 0; ex = 0; ey = 0; nxt_pend = 0;
        if (rise) begin
            m_started = 1; m_done = 0; m_k = 0; m_L = 0; m_inline = 0;
            chk_blk = 1;
        end else if (m_started && !m_done) begin
            if (de) begin
                m_inline = 1;
                m_k++;
                if (m_k > W) begin
                    m_err = 1;
                end else begin
                    eh = (m_k % HPX) == 0;
                    ex = (m_k - 1) / HPX;
                    ey = (m_L / VPX) % VBLKS;
                    chk_blk = 1;
                    if (m_k == W && (m_L % VPX) == VPX - 1) begin
                        nxt_pend = 1;
                        m_vrow = ey;
                    end
                end
            end else if (m_inline) begin
                if (m_k < W) m_err = 1;
                m_L++; m_k = 0; m_inline = 0;
            end
            if (m_vpend && m_vrow == VBLKS - 1) m_done = 1;
        end
        m_vpend = nxt_pend;

        @(posedge clk);
        #1;
        check_value("de_o", 32'(de_o), 32'(de));
        check_value("wd_o", 32'(wd_o), 32'(wd));
        check_value("h_save_o", 32'(h_save_o), 32'(eh));
        check_value("v_save_o", 32'(v_save_o), 32'(ev));
        check_value("frame_start_o", 32'(frame_start_o), 32'(rise));
        check_value("err_o", 32'(err_o), 32'(m_err));
        if (chk_blk) begin
            check_value("blk_x_o", 32'(blk_x_o), 32'(ex));
            check_value("blk_y_o", 32'(blk_y_o), 32'(ey));
        end
    endtask

    task automatic send_line(input int len, input int blank);
        for (int i = 0; i < len; i++) step(0, 1);
        for (int i = 0; i < blank; i++) step(0, 0);
    endtask

    task automatic vs_pulse();
        step(1, 0);
        step(0, 0);
    endtask

    // Reset asserted between edges: outputs must clear without a clock edge.
    task automatic do_reset();
        #2 rst_ni = 1'b0;
        #1;
        check_zero("rst_async");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero("rst_hold");
        rst_ni = 1'b1;
    endtask

    initial begin
        model_reset();
        rst_ni = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero("reset");
        rst_ni = 1'b1;

        // de_i before any vs_i: ignored
        send_line(6, 2);

        // Full frame, then an extra line while DONE, then a new frame
        vs_pulse();
        for (int l = 0; l < 4; l++) send_line(6, 2);
        send_line(6, 2);
        vs_pulse();

        // Short line, full line, long line, full line
        send_line(4, 2);
        send_line(6, 2);
        send_line(8, 2);
        send_line(6, 2);

        // vs_i rising in the middle of a line
        vs_pulse();
        send_line(2, 0);
        step(1, 1);
        step(0, 1);
        step(0, 1);
        step(0, 1);
        step(0, 0);

        // Reset during ACTIVE, then de_i without vs_i
        vs_pulse();
        step(0, 1);
        step(0, 1);
        do_reset();
        send_line(6, 2);
        vs_pulse();
        send_line(6, 1);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 29);
            if (r == 0) begin
                step(1, 1'($urandom_range(0, 1)));
                step(0, 0);
            end else if (r == 1 && n % 3 == 0) begin
                do_reset();
            end else begin
                int len;
                len = ($urandom_range(0, 9) < 7) ? W : $urandom_range(1, 8);
                for (int i = 0; i < len; i++) step(($urandom_range(0, 60) == 0), 1);
                send_line(0, $urandom_range(1, 3));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/blk_sequencer.md
BLK_SEQUENCER -- requirements
Module: blk_sequencer

Interface
REQ-001 Parameter HBLKS, default 10: horizontal blocks per line.
REQ-002 Parameter VBLKS, default 10: vertical blocks per frame.
REQ-003 Parameter HPX, default 30: pixels per block horizontally.
REQ-004 Parameter VPX, default 30: lines per block vertically.
REQ-005 clk_i  input  1  clock; all logic on rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 vs_i  input  1  vertical sync, active high.
REQ-008 de_i  input  1  data enable, high during active pixels.
REQ-009 wd_i  input  24  pixel RGB, valid when de_i high.
REQ-010 de_o  output  1  de_i delayed one cycle.
REQ-011 wd_o  output  24  wd_i delayed one cycle.
REQ-012 h_save_o  output  1  pulse marking last pixel of a horizontal block, aligned with de_o.
REQ-013 v_save_o  output  1  pulse marking completion of a block row.
REQ-014 frame_start_o  output  1  pulse on detected vs_i rising edge.
REQ-015 blk_x_o  output  $clog2(HBLKS)  block column of current de_o pixel.
REQ-016 blk_y_o  output  $clog2(VBLKS)  block row of current de_o pixel.
REQ-017 err_o  output  1  sticky timing-error flag.

Function
REQ-018 FSM states IDLE, ACTIVE, HBLANK, DONE; only IDLE is exited by vs_i.
REQ-019 vs_i rising edge (vs_i high, previous sample low) in any state: clear all counters, enter HBLANK, pulse frame_start_o next cycle.
REQ-020 Counters: px (0..HPX-1), hblk (0..HBLKS-1), line (0..VPX-1), vblk (0..VBLKS-1); all wrap to 0.
REQ-021 HBLANK -> ACTIVE when de_i high; ACTIVE -> HBLANK when de_i low.
REQ-022 In ACTIVE each de_i-high cycle increments px; at px==HPX-1, h_save_o asserts the following cycle, px wraps, hblk increments.
REQ-023 Line end (ACTIVE -> HBLANK): px, hblk cleared; line increments; at line==VPX-1, line wraps and vblk increments.
REQ-024 v_save_o asserts exactly one cycle after the h_save_o of block HBLKS-1 on line VPX-1 of every block row.
REQ-025 After v_save_o of row VBLKS-1, enter DONE; in DONE, de_i ignored, h_save_o/v_save_o held 0 until next vs_i rising edge.
REQ-026 Pixels after HBLKS*HPX in one line: no h_save_o, set err_o.
REQ-027 Line ending with fewer than HBLKS*HPX pixels: set err_o; line still counted; no h_save_o for partial block.
REQ-028 de_i high in IDLE (no vs_i yet): ignored, no pulses.
REQ-029 de_o, wd_o always one-cycle delayed copies, in every state; blk_x_o/blk_y_o registered with same alignment.
REQ-030 h_save_o and de_o pixel coincide; h_save_o never asserts while de_o low.
REQ-031 err_o cleared only by reset.

Reset
REQ-032 Reset asserted: state IDLE; all counters, de_o, wd_o, h_save_o, v_save_o, frame_start_o, blk_x_o, blk_y_o, err_o = 0, vs_i edge history = 0.
REQ-033 Reset mid-frame: outputs cleared immediately; after release, no pulses until next vs_i rising edge.

Verification (HBLKS=2, VBLKS=2, HPX=3, VPX=2)
REQ-034 vs_i pulse, then 4 lines of 6 de_i cycles -> h_save_o at line pixels 3,6 (one cycle late); v_save_o after lines 2 and 4; err_o=0.
REQ-035 Fifth line after full frame -> no h_save_o/v_save_o; DONE held until next vs_i.
REQ-036 Line of 4 pixels -> one h_save_o, err_o=1 sticky; next full line gives normal pulses.
REQ-037 Line of 8 pixels -> two h_save_o, none for pixels 7-8, err_o=1.
REQ-038 vs_i rising mid-line -> frame_start_o pulse, counters cleared, blk_x_o/blk_y_o=0 on next pixel.
REQ-039 rst_ni low during ACTIVE -> all outputs 0 asynchronously; de_i without vs_i after release -> no pulses.
